// File: rtl/picorv32_sram_bridge.sv
// Bridge from the picorv32 native memory interface to a single-port synchronous SRAM.
// Define SRAM_BRIDGE_RANGE_CHECK_EN to flag and suppress out-of-range requests.
module picorv32_sram_bridge #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mem_valid,
    input  logic                  mem_instr,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wstrb,
    output logic                  mem_ready,
    output logic [31:0]           mem_rdata,
    output logic                  sram_en,
    output logic [3:0]            sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata,
    output logic                  bus_err
);
    typedef enum logic [2:0] {IDLE, WAIT, ACCESS, CAPTURE, RESP} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  oor_q, oor_d;
    logic                  err_q, err_d;
    logic                  reqOor;
    logic                  unusedInputs;

`ifdef SRAM_BRIDGE_RANGE_CHECK_EN
    assign reqOor = (mem_addr >> (ADDR_WIDTH + 2)) != 32'd0;
`else
    assign reqOor = 1'b0;
`endif

    // Fetch flag and byte-offset bits carry no meaning for a word-wide SRAM.
    assign unusedInputs = ^{mem_instr, mem_addr[1:0], mem_addr >> (ADDR_WIDTH + 2)};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            oor_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            oor_q   <= oor_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        oor_d   = oor_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    addr_d  = mem_addr[ADDR_WIDTH+1:2];
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    oor_d   = reqOor;
                    err_d   = err_q | reqOor;
                    cnt_d   = 4'(WAIT_STATES - 1);
                    state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACCESS: state_d = CAPTURE;
            CAPTURE: begin
                // Writes and suppressed requests answer with zero rather than stale SRAM data.
                rdata_d = (wstrb_q == 4'd0 && !oor_q) ? sram_rdata : 32'd0;
                state_d = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sram_en   = 1'b0;
        sram_we   = 4'd0;
        mem_ready = 1'b0;
        if (state_q == ACCESS && !oor_q) begin
            sram_en = 1'b1;
            sram_we = wstrb_q;
        end
        if (state_q == RESP) begin
            mem_ready = 1'b1;
        end
    end

    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign mem_rdata  = rdata_q;
    assign bus_err    = err_q;
endmodule

// File: tb/tb_picorv32_sram_bridge.sv
// Randomized bench: a zero-wait and a three-wait bridge share stimulus, each with its own SRAM
// and reference memory; timing is predicted from the request cycle and the wait-state count.
module tb_picorv32_sram_bridge;
    localparam int AW = 10;
    localparam int DEPTH = 1 << AW;
`ifdef SRAM_BRIDGE_RANGE_CHECK_EN
    localparam bit RangeCheckOn = 1'b1;
`else
    localparam bit RangeCheckOn = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    logic memValid, memInstr;
    logic [31:0] memAddr, memWdata;
    logic [3:0] memWstrb;

    logic ready0, en0, err0, ready3, en3, err3;
    logic [31:0] rdata0, wdata0, srRd0, rdata3, wdata3, srRd3;
    logic [3:0] we0, we3;
    logic [AW-1:0] addr0, addr3;

    logic [31:0] sram0 [0:DEPTH-1];
    logic [31:0] sram3 [0:DEPTH-1];
    logic [31:0] ref0 [0:DEPTH-1];
    logic [31:0] ref3 [0:DEPTH-1];

    int checks = 0;
    int failures = 0;
    bit stickyErr = 1'b0;

    always #5 clock = ~clock;

    picorv32_sram_bridge #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
        .clock(clock), .reset(reset), .mem_valid(memValid), .mem_instr(memInstr),
        .mem_addr(memAddr), .mem_wdata(memWdata), .mem_wstrb(memWstrb),
        .mem_ready(ready0), .mem_rdata(rdata0), .sram_en(en0), .sram_we(we0),
        .sram_addr(addr0), .sram_wdata(wdata0), .sram_rdata(srRd0), .bus_err(err0));

    picorv32_sram_bridge #(.ADDR_WIDTH(AW), .WAIT_STATES(3)) dut3 (
        .clock(clock), .reset(reset), .mem_valid(memValid), .mem_instr(memInstr),
        .mem_addr(memAddr), .mem_wdata(memWdata), .mem_wstrb(memWstrb),
        .mem_ready(ready3), .mem_rdata(rdata3), .sram_en(en3), .sram_we(we3),
        .sram_addr(addr3), .sram_wdata(wdata3), .sram_rdata(srRd3), .bus_err(err3));

    // Behavioural SRAMs: byte-masked write, one-cycle read latency.
    always @(posedge clock) begin
        if (en0) begin
            for (int b = 0; b < 4; b++)
                if (we0[b]) sram0[addr0][b*8 +: 8] <= wdata0[b*8 +: 8];
            srRd0 <= sram0[addr0];
        end
        if (en3) begin
            for (int b = 0; b < 4; b++)
                if (we3[b]) sram3[addr3][b*8 +: 8] <= wdata3[b*8 +: 8];
            srRd3 <= sram3[addr3];
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] mergeBytes(logic [31:0] old, logic [31:0] wd, logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // With valid held for cycles 0..hold, requests start every 4+w cycles.
    function automatic bit evAt(int k, int w, int hold, int off);
        for (int s = 0; s <= hold; s += 4 + w)
            if (k == s + off + w) return 1'b1;
        return 1'b0;
    endfunction

    task automatic scrambleIdle();
        memValid = 1'b0;
        memInstr = 1'($urandom);
        memAddr  = $urandom;
        memWdata = $urandom;
        memWstrb = 4'($urandom);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".dut0"}, {en0, we0, addr0, wdata0, ready0, rdata0, err0}, '0);
        checkOutput({tag, ".dut3"}, {en3, we3, addr3, wdata3, ready3, rdata3, err3}, '0);
    endtask

    task automatic pulseReset(input string tag);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        stickyErr = 1'b0;
        checkResetState(tag);
    endtask

    task automatic checkCycle(input string name, input int k, input int w, input int hold, input bit oor,
                              input logic [AW-1:0] expAddr, input logic [31:0] expWd,
                              input logic [3:0] expWe, input logic [31:0] expRd,
                              input logic en, input logic [3:0] we, input logic [AW-1:0] addr,
                              input logic [31:0] wd, input logic ready, input logic [31:0] rd,
                              input logic err);
        bit expEn;
        bit expReady;
        expEn = evAt(k, w, hold, 1) && !oor;
        expReady = evAt(k, w, hold, 3);
        checkOutput($sformatf("%s.en@%0d", name, k), en, expEn);
        checkOutput($sformatf("%s.ready@%0d", name, k), ready, expReady);
        checkOutput($sformatf("%s.busErr@%0d", name, k), err, stickyErr);
        if (expEn) begin
            checkOutput($sformatf("%s.addr@%0d", name, k), addr, expAddr);
            checkOutput($sformatf("%s.we@%0d", name, k), we, expWe);
            checkOutput($sformatf("%s.wdata@%0d", name, k), wd, expWd);
        end
        if (expReady)
            checkOutput($sformatf("%s.rdata@%0d", name, k), rd, expRd);
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st, input int hold);
        bit oor;
        logic [AW-1:0] word;
        logic [31:0] expRd0, expRd3;
        oor = RangeCheckOn && (a[31:AW+2] != '0);
        word = a[AW+1:2];
        expRd0 = (st == 4'd0 && !oor) ? ref0[word] : 32'd0;
        expRd3 = (st == 4'd0 && !oor) ? ref3[word] : 32'd0;
        memValid = 1'b1;
        memInstr = 1'($urandom);
        memAddr  = a;
        memWdata = wd;
        memWstrb = st;
        for (int k = 1; k <= hold + 8; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (oor) stickyErr = 1'b1;
            checkCycle("w0", k, 0, hold, oor, word, wd, st, expRd0,
                       en0, we0, addr0, wdata0, ready0, rdata0, err0);
            checkCycle("w3", k, 3, hold, oor, word, wd, st, expRd3,
                       en3, we3, addr3, wdata3, ready3, rdata3, err3);
            if (k > hold) scrambleIdle();
        end
        if (st != 4'd0 && !oor) begin
            ref0[word] = mergeBytes(ref0[word], wd, st);
            ref3[word] = mergeBytes(ref3[word], wd, st);
        end
    endtask

    // A write to word 16 is aborted by reset during the second wait cycle of the three-wait bridge;
    // the zero-wait bridge has already strobed its SRAM by then.
    task automatic applyAbort();
        logic [31:0] wd;
        wd = $urandom;
        memValid = 1'b1;
        memAddr  = 32'h40;
        memWdata = wd;
        memWstrb = 4'hF;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (k == 1) begin
                checkOutput("abort.en0", en0, 1'b1);
                scrambleIdle();
            end
            if (k == 2) begin
                reset = 1'b1;
                stickyErr = 1'b0;
            end
            if (k == 3) begin
                reset = 1'b0;
                checkResetState("abort.rst");
            end
            if (k >= 3) begin
                checkOutput($sformatf("abort.en3@%0d", k), en3, 1'b0);
                checkOutput($sformatf("abort.ready3@%0d", k), ready3, 1'b0);
                checkOutput($sformatf("abort.ready0@%0d", k), ready0, 1'b0);
            end
        end
        ref0[16] = mergeBytes(ref0[16], wd, 4'hF);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] a;
        logic [3:0] st;
        int hold;
        reset = 1'b1;
        scrambleIdle();
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            sram0[i] <= v;
            sram3[i] <= v;
            ref0[i] = v;
            ref3[i] = v;
        end
        sram0[5] <= 32'h1234_5678;
        sram3[5] <= 32'h1234_5678;
        ref0[5] = 32'h1234_5678;
        ref3[5] = 32'h1234_5678;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkResetState("reset");
        reset = 1'b0;

        applyStimulus(32'h14, 32'h0, 4'd0, 0);
        applyStimulus(32'h20, 32'hAABB_CCDD, 4'b0100, 0);
        applyStimulus(32'h20, 32'h0, 4'd0, 0);
        checkOutput("byteMerge", ref0[8][23:16], 8'hBB);
        applyStimulus(32'h14, 32'h0, 4'd0, 12);
        applyAbort();
        applyStimulus(32'h40, 32'h0, 4'd0, 0);

        applyStimulus(32'h0000_1004, 32'h0, 4'd0, 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("errHold0", err0, stickyErr);
        checkOutput("errHold3", err3, stickyErr);
        pulseReset("errClear");

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 7) == 0)
                a = $urandom;
            else
                a = {20'd0, 10'($urandom_range(0, DEPTH - 1)), 2'($urandom)};
            st = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : 0;
            applyStimulus(a, $urandom, st, hold);
        end
        pulseReset("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/picorv32_sram_bridge.md
# picorv32_sram_bridge

Memory-side responder for the picorv32 native memory interface. Accepts one `mem_valid`/`mem_ready` transaction at a time, applies a fixed number of wait states, and drives a single-port synchronous SRAM with one-cycle read latency and byte write strobes. Sits directly downstream of the core, taking the place of the free-running `mem_ready`/`mem_rdata` sources used in formal runs, so the same core can be simulated and bounded-checked against real storage.

## Interface
- `ADDR_WIDTH`, 10, SRAM word-address width; capacity is 2^ADDR_WIDTH 32-bit words.
- `WAIT_STATES`, 0, extra cycles inserted before the SRAM access; legal range 0..15.

- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_valid` in 1: core request valid.
- `mem_instr` in 1: request is an instruction fetch; informational only, no behavioural effect.
- `mem_addr` in 32: byte address; bits [1:0] ignored.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: byte write enables; 0 means read.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_rdata` out 32: read data, valid while `mem_ready`=1.
- `sram_en` out 1: SRAM access strobe.
- `sram_we` out 4: SRAM byte write enables, qualified by `sram_en`.
- `sram_addr` out ADDR_WIDTH: SRAM word address.
- `sram_wdata` out 32: SRAM write data.
- `sram_rdata` in 32: SRAM read data, valid the cycle after a read strobe.
- `bus_err` out 1: sticky out-of-range flag (see Configuration).

## Operation
- FSM states: IDLE, WAIT, ACCESS, CAPTURE, RESP.
- IDLE: when `mem_valid`=1, latch `mem_addr`, `mem_wdata`, `mem_wstrb` into request registers. Go to WAIT if WAIT_STATES>0, otherwise go to ACCESS. Load the 4-bit wait counter with WAIT_STATES-1.
- WAIT: decrement the counter each cycle. At 0, go to ACCESS.
- ACCESS: `sram_en`=1; `sram_we`=latched wstrb; `sram_addr`=latched addr[ADDR_WIDTH+1:2]; `sram_wdata`=latched wdata. Go to CAPTURE.
- CAPTURE: on a read (wstrb==0), register `sram_rdata` into the rdata register. On a write, load the rdata register with 0. Go to RESP.
- RESP: `mem_ready`=1, `mem_rdata`=rdata register. Go to IDLE unconditionally.
- `mem_valid` is still high during the RESP cycle. It is not sampled there, so no second transaction starts. A new request is accepted no earlier than the IDLE cycle that follows.
- Request inputs are not re-sampled after IDLE. Changes or a drop of `mem_valid` mid-transaction are ignored, and the transaction completes.
- `sram_en`, `sram_we`, and `mem_ready` decode from the state register only, with no combinational path from core inputs. `sram_addr`, `sram_wdata`, and `mem_rdata` are driven from registers and hold their last value outside their qualifying state.

## Timing
- Request seen in IDLE at cycle N:
  - `sram_en` is high in cycle N+1+WAIT_STATES.
  - `mem_ready` is high in cycle N+3+WAIT_STATES.
- Minimum spacing between successive `mem_ready` pulses: 4+WAIT_STATES cycles.
- Reset values: state IDLE, counter 0, `mem_ready`=0, `mem_rdata`=0, `sram_en`=0, `sram_we`=0, `sram_addr`=0, `sram_wdata`=0, `bus_err`=0.
- Reset asserted in any state returns the FSM to IDLE at the next edge, and no `mem_ready` is produced for the aborted request. Because reset is synchronous, a strobe already driven during the ACCESS cycle in which reset is sampled still reaches the SRAM, so that write does take effect.
- Reset and `mem_valid` both high in IDLE: reset wins and nothing is latched.

## Configuration
- Controlled by `SRAM_BRIDGE_RANGE_CHECK_EN`.
- Defined:
  - At latch time, if mem_addr[31:ADDR_WIDTH+2] is nonzero, the request is flagged out-of-range.
  - A flagged request suppresses `sram_en` in ACCESS (no SRAM read or write) and returns `mem_rdata`=0.
  - It still produces `mem_ready` with normal latency.
  - `bus_err` sets at the edge ending IDLE and is cleared only by reset.
- Undefined:
  - Upper address bits are ignored, so addresses wrap modulo 2^(ADDR_WIDTH+2) bytes.
  - `bus_err` is tied 0.

## Test plan
- Read, WAIT_STATES=0, with SRAM word 5 = 32'h1234_5678: request `mem_addr`=32'h14, wstrb=0 at cycle N. Required: `sram_en`=1, `sram_addr`=5 at N+1; `mem_ready`=1, `mem_rdata`=32'h1234_5678 at N+3 only.
- Byte write: `mem_addr`=32'h20, wdata=32'hAABB_CCDD, wstrb=4'b0100. Required: `sram_we`=4'b0100, `sram_addr`=8 with `sram_en`=1. Readback of word 8 returns byte 2 = 8'hBB with other bytes unchanged. `mem_rdata`=0 during the write's `mem_ready`.
- WAIT_STATES=3, back-to-back requests with `mem_valid` held high: `mem_ready` at N+6 and again at N+13. Exactly one `sram_en` per transaction.
- Reset asserted in the second WAIT cycle (WAIT_STATES=3, write request): no `sram_en`, no `mem_ready`, and all outputs at reset values the next cycle. The SRAM word is unchanged.
- `mem_addr`=32'h0000_1004 with ADDR_WIDTH=10:
  - Macro defined: no `sram_en`, `mem_ready` with `mem_rdata`=0, `bus_err`=1 held until reset.
  - Macro undefined: access to word 1 and `bus_err`=0.
